lcd_hex_calc: RTL and testbench

Parametrised operand-load calculator with a character-LCD front end, successor to the team's 4-bit adder/LCD block. Loads two WIDTH-bit operands from shared switches, computes sum (or difference), and continuously mirrors carry plus the full hex result on a 4-bit-mode HD44780-style LCD. A proper init/refresh state machine rewrites the display only when the result changes; a free-running counter does not drive it. Sits at board top level between the switch/button inputs and the LCD pins.

---
 rtl/lcd_calc_pkg.sv | 41 ++++
 rtl/lcd_nibble_tx.sv | 69 ++++++
 rtl/lcd_hex_calc.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_lcd_hex_calc.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_calc_pkg
// Description : Shared types and constants for the hex calculator LCD
//               front end: display FSM state encoding, HD44780 command
//               bytes, fixed characters and the nibble-to-ASCII helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_calc_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP    = 3'd0,
        ST_INIT     = 3'd1,
        ST_CONFIG   = 3'd2,
        ST_CLR_WAIT = 3'd3,
        ST_IDLE     = 3'd4,
        ST_HOME     = 3'd5,
        ST_DIGITS   = 3'd6
    } lcd_state_t;

    // HD44780 command bytes
    localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h28;  // 4-bit bus, 2 lines, 5x8
    localparam logic [7:0] LCD_CMD_ENTRY_MODE = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_CMD_DISP_ON    = 8'h0C;  // display on, no cursor
    localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME       = 8'h80;  // DDRAM address 0

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;  // OR in the carry bit for '0'/'1'

    // 0-9 -> '0'-'9', 10-15 -> 'a'-'f'
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] v);
        if (v < 4'd10)
            return 8'h30 + {4'h0, v};
        else
            return 8'h57 + {4'h0, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_nibble_tx.sv
`default_nettype none
// ============================================================================
// Module      : lcd_nibble_tx
// Description : Drives one 4-bit LCD transfer per start pulse. rs and the
//               data nibble are held for STEP_CYCLES clocks; E is high for
//               step cycles STEP/4 .. 3*STEP/4-1. A new start may be issued
//               in the same cycle as done, giving back-to-back steps.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               start           - begin a transfer with start_rs/start_d
//               start_rs        - register select for this nibble
//               start_d         - nibble value
//               done            - last cycle of the current step
//               active          - a step is in progress
//               lcd_e           - enable strobe
//               lcd_rs, lcd_d   - held register select and nibble
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_nibble_tx #(
    parameter int STEP_CYCLES = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       start_rs,
    input  logic [3:0] start_d,
    output logic       done,
    output logic       active,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] lcd_d
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] C_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] C_E_ON  = CW'(STEP_CYCLES / 4);
    localparam logic [CW-1:0] C_E_OFF = CW'((3 * STEP_CYCLES) / 4 - 1);

    logic [CW-1:0] r_cnt;
    logic          r_active;
    logic          r_rs;
    logic [3:0]    r_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_rs     <= 1'b0;
            r_d      <= 4'h0;
        end else if (start) begin
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_rs     <= start_rs;
            r_d      <= start_d;
        end else if (done) begin
            r_active <= 1'b0;
        end else if (r_active) begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign done   = r_active && (r_cnt == C_LAST);
    assign active = r_active;
    // Decoded from registered state so that reset removes E immediately
    assign lcd_e  = r_active && (r_cnt >= C_E_ON) && (r_cnt <= C_E_OFF);
    assign lcd_rs = r_rs;
    assign lcd_d  = r_d;

endmodule
`default_nettype wire

// File: rtl/lcd_hex_calc.sv
`default_nettype none
// ============================================================================
// Module      : lcd_hex_calc
// Description : Two-operand WIDTH-bit calculator with an HD44780 4-bit-mode
//               display. Operands load from shared switches, the registered
//               result and carry are shown as "<carry> <hex digits>", and
//               the display is refreshed only when the result changes.
// Config      : LCD_CALC_SUB_EN - when defined, op=1 selects A-B with
//               borrow; otherwise op is ignored and the block always adds.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               p               - operand value from switches
//               set1, set2      - load p into A / B (set1 wins)
//               op              - 0 add, 1 subtract
//               result, carry   - registered A op B, carry/borrow
//               busy            - display FSM not idle
//               sf_e, lcd_e, lcd_rs, lcd_rw, lcd_d - LCD pins
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_hex_calc
    import lcd_calc_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int STEP_CYCLES  = 2048,
    parameter int PWRUP_CYCLES = 750000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p,
    input  logic             set1,
    input  logic             set2,
    input  logic             op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             busy,
    output logic             sf_e,
    output logic             lcd_e,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic [3:0]       lcd_d
);

    localparam int         DIGITS = WIDTH / 4;
    localparam logic [5:0] N_INIT = 6'd4;
    localparam logic [5:0] N_CFG  = 6'd8;
    localparam logic [5:0] N_HOME = 6'd2;
    localparam logic [5:0] N_DIG  = 6'(2 * (DIGITS + 2));

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_a, r_b, r_result, r_prev_result, r_snap_result;
    logic             r_carry, r_prev_carry, r_snap_carry;
    logic             w_changed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a           <= '0;
            r_b           <= '0;
            r_result      <= '0;
            r_carry       <= 1'b0;
            r_prev_result <= '0;
            r_prev_carry  <= 1'b0;
        end else begin
            if (set1)
                r_a <= p;
            else if (set2)
                r_b <= p;
`ifdef LCD_CALC_SUB_EN
            // Bit WIDTH of the extended difference is the borrow (A < B)
            if (op)
                {r_carry, r_result} <= {1'b0, r_a} - {1'b0, r_b};
            else
                {r_carry, r_result} <= {1'b0, r_a} + {1'b0, r_b};
`else
            {r_carry, r_result} <= {1'b0, r_a} + {1'b0, r_b};
`endif
            r_prev_result <= r_result;
            r_prev_carry  <= r_carry;
        end
    end

`ifndef LCD_CALC_SUB_EN
    logic w_unused_op;
    assign w_unused_op = op;
`endif

    assign w_changed = (r_result != r_prev_result) || (r_carry != r_prev_carry);
    assign result    = r_result;
    assign carry     = r_carry;

    // ------------------------------------------------------------------
    // Display sequencer
    // ------------------------------------------------------------------
    lcd_state_t  r_state, w_state_nx, w_sel_state;
    logic [5:0]  r_idx, w_idx_nx, w_sel_idx, w_cur_n;
    logic [31:0] r_wait, w_wait_nx;
    logic        r_dirty;
    logic        w_start, w_snap, w_force_dirty;
    logic        w_tx_done, w_tx_active, w_tx_ready;
    logic        w_tx_rs;
    logic [3:0]  w_tx_d;
    logic [7:0]  w_byte;
    logic [4:0]  w_char;

    assign w_tx_ready = !w_tx_active || w_tx_done;

    always_comb begin
        w_cur_n = N_DIG;
        case (r_state)
            ST_INIT:   w_cur_n = N_INIT;
            ST_CONFIG: w_cur_n = N_CFG;
            ST_HOME:   w_cur_n = N_HOME;
            default:   w_cur_n = N_DIG;
        endcase
    end

    // Next state. Where one sending state hands over to another (and on
    // IDLE -> HOME) the first nibble of the new state is launched in the
    // handover cycle so the steps run back to back.
    always_comb begin
        w_state_nx    = r_state;
        w_idx_nx      = r_idx;
        w_wait_nx     = r_wait;
        w_start       = 1'b0;
        w_sel_state   = r_state;
        w_sel_idx     = r_idx;
        w_snap        = 1'b0;
        w_force_dirty = 1'b0;
        case (r_state)
            ST_PWRUP: begin
                if (r_wait == 32'd0) begin
                    w_state_nx = ST_INIT;
                    w_idx_nx   = 6'd0;
                end else begin
                    w_wait_nx  = r_wait - 32'd1;
                end
            end
            ST_INIT, ST_CONFIG, ST_HOME, ST_DIGITS: begin
                if (w_tx_ready) begin
                    if (r_idx < w_cur_n) begin
                        w_start  = 1'b1;
                        w_idx_nx = r_idx + 6'd1;
                    end else begin
                        case (r_state)
                            ST_INIT: begin
                                w_state_nx  = ST_CONFIG;
                                w_start     = 1'b1;
                                w_sel_state = ST_CONFIG;
                                w_sel_idx   = 6'd0;
                                w_idx_nx    = 6'd1;
                            end
                            ST_CONFIG: begin
                                w_state_nx = ST_CLR_WAIT;
                                w_wait_nx  = 32'(CLEAR_CYCLES - 1);
                            end
                            ST_HOME: begin
                                w_state_nx  = ST_DIGITS;
                                w_start     = 1'b1;
                                w_sel_state = ST_DIGITS;
                                w_sel_idx   = 6'd0;
                                w_idx_nx    = 6'd1;
                            end
                            default: begin
                                w_state_nx = ST_IDLE;
                                w_idx_nx   = 6'd0;
                            end
                        endcase
                    end
                end
            end
            ST_CLR_WAIT: begin
                if (r_wait == 32'd0) begin
                    w_force_dirty = 1'b1;
                    w_state_nx    = ST_IDLE;
                end else begin
                    w_wait_nx     = r_wait - 32'd1;
                end
            end
            ST_IDLE: begin
                if (r_dirty) begin
                    w_snap      = 1'b1;
                    w_state_nx  = ST_HOME;
                    w_start     = 1'b1;
                    w_sel_state = ST_HOME;
                    w_sel_idx   = 6'd0;
                    w_idx_nx    = 6'd1;
                end
            end
            default: begin
                w_state_nx = ST_PWRUP;
                w_wait_nx  = 32'(PWRUP_CYCLES - 1);
            end
        endcase
    end

    // Nibble lookup for (state, index); even index = high nibble
    always_comb begin
        w_tx_rs = 1'b0;
        w_tx_d  = 4'h0;
        w_byte  = 8'h00;
        w_char  = w_sel_idx[5:1];
        case (w_sel_state)
            ST_INIT: begin
                w_tx_d = (w_sel_idx == 6'd3) ? 4'h2 : 4'h3;
            end
            ST_CONFIG: begin
                case (w_sel_idx[2:1])
                    2'd0:    w_byte = LCD_CMD_FUNC_SET;
                    2'd1:    w_byte = LCD_CMD_ENTRY_MODE;
                    2'd2:    w_byte = LCD_CMD_DISP_ON;
                    default: w_byte = LCD_CMD_CLEAR;
                endcase
                w_tx_d = w_sel_idx[0] ? w_byte[3:0] : w_byte[7:4];
            end
            ST_HOME: begin
                w_byte = LCD_CMD_HOME;
                w_tx_d = w_sel_idx[0] ? w_byte[3:0] : w_byte[7:4];
            end
            ST_DIGITS: begin
                w_tx_rs = 1'b1;
                if (w_char == 5'd0)
                    w_byte = CHAR_ZERO | {7'd0, r_snap_carry};
                else if (w_char == 5'd1)
                    w_byte = CHAR_SPACE;
                for (int k = 0; k < DIGITS; k++) begin
                    if (w_char == 5'(k + 2))
                        w_byte = hex_to_ascii(r_snap_result[(DIGITS-1-k)*4 +: 4]);
                end
                w_tx_d = w_sel_idx[0] ? w_byte[3:0] : w_byte[7:4];
            end
            default: begin
                w_tx_d = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_PWRUP;
            r_idx   <= 6'd0;
            r_wait  <= 32'(PWRUP_CYCLES - 1);
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_wait  <= w_wait_nx;
        end
    end

    // A change coinciding with a snapshot keeps dirty set, costing at most
    // one redundant frame rather than a missed update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dirty       <= 1'b0;
            r_snap_result <= '0;
            r_snap_carry  <= 1'b0;
        end else begin
            if (w_changed || w_force_dirty)
                r_dirty <= 1'b1;
            else if (w_snap)
                r_dirty <= 1'b0;
            if (w_snap) begin
                r_snap_result <= r_result;
                r_snap_carry  <= r_carry;
            end
        end
    end

    lcd_nibble_tx #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .start_rs (w_tx_rs),
        .start_d  (w_tx_d),
        .done     (w_tx_done),
        .active   (w_tx_active),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_d    (lcd_d)
    );

    assign busy   = (r_state != ST_IDLE);
    assign sf_e   = 1'b1;
    assign lcd_rw = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hex_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_hex_calc
// Description : Self-checking bench for lcd_hex_calc. A monitor decodes LCD
//               E strobes into a nibble log; expected frames are built as
//               text from a plain-arithmetic model of the calculator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_hex_calc;

    localparam int WIDTH      = 8;
    localparam int STEP       = 8;
    localparam int PWRUP      = 20;
    localparam int CLEAR      = 10;
    localparam int FRAME_NIBS = 2 + 2 * (WIDTH / 4 + 2);

`ifdef LCD_CALC_SUB_EN
    localparam bit SUB_MODE = 1'b1;
`else
    localparam bit SUB_MODE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] p = '0;
    logic             set1 = 1'b0, set2 = 1'b0, op = 1'b0;
    logic [WIDTH-1:0] result;
    logic             carry, busy, sf_e, lcd_e, lcd_rs, lcd_rw;
    logic [3:0]       lcd_d;

    lcd_hex_calc #(
        .WIDTH        (WIDTH),
        .STEP_CYCLES  (STEP),
        .PWRUP_CYCLES (PWRUP),
        .CLEAR_CYCLES (CLEAR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .p      (p),
        .set1   (set1),
        .set2   (set2),
        .op     (op),
        .result (result),
        .carry  (carry),
        .busy   (busy),
        .sf_e   (sf_e),
        .lcd_e  (lcd_e),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_d  (lcd_d)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // LCD monitor: nibble at E rise, nibble at E fall, rise time, E width
    logic [4:0] nib_q[$];
    logic [4:0] fall_q[$];
    int         rise_q[$];
    int         width_q[$];
    int         hi_cnt = 0;
    logic       e_prev = 1'b0;

    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            nib_q.push_back({lcd_rs, lcd_d});
            rise_q.push_back(cyc);
            hi_cnt = 1;
        end else if (lcd_e) begin
            hi_cnt = hi_cnt + 1;
        end
        if (!lcd_e && e_prev) begin
            fall_q.push_back({lcd_rs, lcd_d});
            width_q.push_back(hi_cnt);
        end
        e_prev = lcd_e;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] dir_a [3] = '{8'h3C, 8'hFF, 8'h05};
    logic [7:0] dir_b [3] = '{8'h5A, 8'h01, 8'h07};
    logic       dir_o [3] = '{1'b0, 1'b0, 1'b1};
    int         init_exp [12] = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {carry, result} from the arithmetic definition
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic o);
        int s;
        if (SUB_MODE && o) begin
            s = int'(a) - int'(b);
            return {s < 0, 8'(s)};
        end
        s = int'(a) + int'(b);
        return {s > 255, 8'(s)};
    endfunction

    task automatic check_frame(input string tag, input int base, input logic c, input logic [7:0] r);
        string      s;
        logic [4:0] exp_q[$];
        byte        ch;
        logic [31:0] obs;
        s = $sformatf("%0d %h", c, r);
        exp_q.push_back(5'h08);
        exp_q.push_back(5'h00);
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            exp_q.push_back({1'b1, ch[7:4]});
            exp_q.push_back({1'b1, ch[3:0]});
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (base >= 0 && base + i < nib_q.size()) ? 32'(nib_q[base + i]) : 32'hDEAD;
            check($sformatf("%s_nib%0d", tag, i), obs, 32'(exp_q[i]));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_result"}, 32'(result), 32'h0);
        check({tag, "_carry"},  32'(carry),  32'h0);
        check({tag, "_busy"},   32'(busy),   32'h1);
        check({tag, "_sf_e"},   32'(sf_e),   32'h1);
        check({tag, "_lcd_e"},  32'(lcd_e),  32'h0);
        check({tag, "_lcd_rs"}, 32'(lcd_rs), 32'h0);
        check({tag, "_lcd_rw"}, 32'(lcd_rw), 32'h0);
        check({tag, "_lcd_d"},  32'(lcd_d),  32'h0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int lows = 0;
        int n = 0;
        repeat (6) @(negedge clk);
        while (lows < 2 && n < budget) begin
            @(negedge clk);
            n++;
            lows = busy ? 0 : lows + 1;
        end
        check({tag, "_settle"}, 32'(lows >= 2), 32'h1);
    endtask

    task automatic wait_digits(input string tag, input int budget);
        int n = 0;
        while (!(lcd_rs && lcd_e) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reach_digits"}, 32'(lcd_rs && lcd_e), 32'h1);
    endtask

    // Boot sequence plus the first "0 00" frame, starting at log index mark
    task automatic check_boot(input string tag, input int mark);
        int span, bad_w, bad_s;
        check({tag, "_count"}, 32'(nib_q.size() - mark), 32'(12 + FRAME_NIBS));
        for (int i = 0; i < 12; i++)
            check($sformatf("%s_init%0d", tag, i),
                  (mark + i < nib_q.size()) ? 32'(nib_q[mark + i]) : 32'hDEAD,
                  32'(init_exp[i]));
        check_frame({tag, "_frame"}, mark + 12, 1'b0, 8'h00);
        span = (nib_q.size() >= mark + 12 + FRAME_NIBS)
             ? rise_q[mark + 11 + FRAME_NIBS] - rise_q[mark + 12] : -1;
        check({tag, "_frame_span"}, 32'(span), 32'((FRAME_NIBS - 1) * STEP));
        bad_w = 0;
        bad_s = 0;
        for (int i = mark; i < width_q.size(); i++) begin
            if (width_q[i] != STEP / 2) bad_w++;
            if (i < nib_q.size() && fall_q[i] !== nib_q[i]) bad_s++;
        end
        check({tag, "_e_width"}, 32'(bad_w), 32'h0);
        check({tag, "_rs_d_stable"}, 32'(bad_s), 32'h0);
        check({tag, "_busy_low"}, 32'(busy), 32'h0);
    endtask

    logic [7:0] ma = 8'h00, mb = 8'h00;

    task automatic load(input logic s1, input logic s2, input logic [7:0] v);
        @(negedge clk);
        p    = v;
        set1 = s1;
        set2 = s2;
        @(negedge clk);
        set1 = 1'b0;
        set2 = 1'b0;
        p    = 8'($urandom);
        if (s1)
            ma = v;
        else if (s2)
            mb = v;
    endtask

    initial begin
        int         mark;
        int         gap;
        logic [8:0] e;
        logic [8:0] e_old;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst  = 1'b0;
        mark = nib_q.size();
        wait_idle("boot", 3000);
        check_boot("boot", mark);

        // Directed then random operand pairs; B loads at random points,
        // often while the frame for A is still on the wire
        for (int t = 0; t < 8; t++) begin
            logic [7:0] a, b;
            logic       o;
            if (t < 3) begin
                a = dir_a[t];
                b = dir_b[t];
                o = dir_o[t];
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
                o = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            op = o;
            load(1'b1, 1'b0, a);
            repeat ($urandom_range(0, 120)) @(negedge clk);
            load(1'b0, 1'b1, b);
            wait_idle($sformatf("vec%0d", t), 2000);
            e = model(ma, mb, o);
            check($sformatf("vec%0d_result", t), 32'(result), 32'(e[7:0]));
            check($sformatf("vec%0d_carry", t),  32'(carry),  32'(e[8]));
            check_frame($sformatf("vec%0d_frame", t), nib_q.size() - FRAME_NIBS, e[8], e[7:0]);
        end

        // Simultaneous set1/set2 while a frame is being written
        @(negedge clk);
        op = 1'b0;
        load(1'b1, 1'b0, 8'h11);
        load(1'b0, 1'b1, 8'h22);
        wait_idle("mid_pre", 2000);
        mark  = nib_q.size();
        load(1'b1, 1'b0, 8'h40);
        e_old = model(ma, mb, 1'b0);
        wait_digits("mid", 500);
        load(1'b1, 1'b1, 8'h99);
        wait_idle("mid", 2000);
        e = model(ma, mb, 1'b0);
        check("mid_result", 32'(result), 32'(e[7:0]));
        check("mid_carry",  32'(carry),  32'(e[8]));
        check("mid_count", 32'(nib_q.size() - mark), 32'(2 * FRAME_NIBS));
        check_frame("mid_old_frame", mark, e_old[8], e_old[7:0]);
        check_frame("mid_new_frame", mark + FRAME_NIBS, e[8], e[7:0]);
        gap = (nib_q.size() >= mark + 2 * FRAME_NIBS)
            ? rise_q[mark + FRAME_NIBS] - rise_q[mark + FRAME_NIBS - 1] : -1;
        check("mid_frame_gap_ok", 32'(gap >= STEP && gap <= STEP + 1), 32'h1);

        // Reset while DIGITS is strobing E
        load(1'b1, 1'b0, 8'h01);
        wait_digits("rstmid", 500);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_e_async", 32'(lcd_e), 32'h0);
        @(negedge clk);
        check_reset("rstmid");
        ma = 8'h00;
        mb = 8'h00;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        mark = nib_q.size();
        wait_idle("reboot", 3000);
        check_boot("reboot", mark);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
